// File: rtl/lfsr_config_master.sv
// lfsr_config_master
// Initiator side of the LFSR configuration handshake. On start it writes the
// captured seed and then the stop value into the LFSR, waits for the done
// echo after each write, reads both registers back, and retries the whole
// sequence on a timeout or a readback mismatch.
module lfsr_config_master #(
    parameter int MAX_PIXEL_BITS = 8,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                             clk_i,
    input  logic                             nreset_i,
    input  logic                             start_i,
    input  logic [MAX_PIXEL_BITS-1:0]        seed_i,
    input  logic [MAX_PIXEL_BITS-1:0]        stop_i,
    output logic                             config_o,
    output logic                             config_rdy_o,
    output logic [MAX_PIXEL_BITS-1:0]        config_data_o,
    input  logic                             config_done_i,
    input  logic [MAX_PIXEL_BITS-1:0]        config_rdata_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retries_o
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SEED,
        S_WAIT_SEED,
        S_WR_STOP,
        S_WAIT_STOP,
        S_VFY_SEED,
        S_VFY_STOP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [MAX_PIXEL_BITS-1:0] seed_q;
    logic [MAX_PIXEL_BITS-1:0] stop_q;
    logic [CW-1:0]             tmo_cnt;
    logic                      accept;
    logic                      fail;
    logic                      in_wait;

    assign in_wait = (state == S_WAIT_SEED) || (state == S_WAIT_STOP);

    // State register; a low nreset_i at an edge aborts any sequence in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block ordering.
        if (!nreset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Moore outputs, including the retry/error decision.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next    = state;
        accept        = 1'b0;
        fail          = 1'b0;
        config_o      = 1'b0;
        config_rdy_o  = 1'b0;
        config_data_o = '0;
        busy_o        = 1'b1;
        done_o        = 1'b0;

        case (state)
            S_IDLE, S_ERROR: begin
                busy_o = 1'b0;
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = S_WR_SEED;
                end
            end
            S_WR_SEED: begin
                config_rdy_o  = 1'b1;
                config_data_o = seed_q;
                state_next    = S_WAIT_SEED;
            end
            S_WAIT_SEED: begin
                config_data_o = seed_q;
                if (config_done_i)              state_next = S_WR_STOP;
                else if (tmo_cnt == TIMEOUT_LAST) fail     = 1'b1;
            end
            S_WR_STOP: begin
                config_o      = 1'b1;
                config_rdy_o  = 1'b1;
                config_data_o = stop_q;
                state_next    = S_WAIT_STOP;
            end
            S_WAIT_STOP: begin
                config_o      = 1'b1;
                config_data_o = stop_q;
                if (config_done_i)              state_next = S_VFY_SEED;
                else if (tmo_cnt == TIMEOUT_LAST) fail     = 1'b1;
            end
            S_VFY_SEED: begin
                if (config_rdata_i == seed_q) state_next = S_VFY_STOP;
                else                          fail       = 1'b1;
            end
            S_VFY_STOP: begin
                config_o = 1'b1;
                if (config_rdata_i == stop_q) state_next = S_DONE;
                else                          fail       = 1'b1;
            end
            S_DONE: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // A failed attempt restarts from the seed write until retries run out.
        if (fail) begin
            state_next = (retries_o < RETRY_LIMIT) ? S_WR_SEED : S_ERROR;
        end
    end

    // Captured operands, retry/error bookkeeping and the WAIT-state timeout.
    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            seed_q    <= '0;
            stop_q    <= '0;
            error_o   <= 1'b0;
            retries_o <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (accept) begin
                seed_q    <= seed_i;
                stop_q    <= stop_i;
                error_o   <= 1'b0;
                retries_o <= '0;
            end else if (fail) begin
                if (retries_o < RETRY_LIMIT) retries_o <= retries_o + RW'(1);
                else                         error_o   <= 1'b1;
            end

            // Counts only while staying in a WAIT state, so it is zero on entry.
            if (in_wait && (state_next == state)) tmo_cnt <= tmo_cnt + CW'(1);
            else                                  tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_lfsr_config_master.sv
// tb_lfsr_config_master
// Drives lfsr_config_master against a small LFSR register model with a
// one-cycle done echo, an optional echo suppressor and an optional one-shot
// readback corruption. Expected strobes are queued when a start is issued and
// popped as the DUT produces them.
module tb_lfsr_config_master;

    localparam int W   = 8;
    localparam int TMO = 8;
    localparam int MR  = 2;

    logic         clk_i = 1'b0;
    logic         nreset_i;
    logic         start_i;
    logic [W-1:0] seed_i;
    logic [W-1:0] stop_i;
    logic         config_o;
    logic         config_rdy_o;
    logic [W-1:0] config_data_o;
    logic         config_done_i;
    logic [W-1:0] config_rdata_i;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic [1:0]   retries_o;

    lfsr_config_master #(
        .MAX_PIXEL_BITS(W),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk_i         (clk_i),
        .nreset_i      (nreset_i),
        .start_i       (start_i),
        .seed_i        (seed_i),
        .stop_i        (stop_i),
        .config_o      (config_o),
        .config_rdy_o  (config_rdy_o),
        .config_data_o (config_data_o),
        .config_done_i (config_done_i),
        .config_rdata_i(config_rdata_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .retries_o     (retries_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- LFSR register model ----------------
    logic [W-1:0] lfsr_seed    = '0;
    logic [W-1:0] lfsr_stop    = '0;
    logic         echo         = 1'b0;
    logic         suppress     = 1'b0;
    int           seed_strobes = 0;
    int           corrupt_at   = -1;
    logic         corrupt_sel  = 1'b0;

    // Model register writes and the registered done echo.
    always @(posedge clk_i) begin
        if (config_rdy_o) begin
            if (config_o) lfsr_stop <= config_data_o;
            else begin
                lfsr_seed    <= config_data_o;
                seed_strobes <= seed_strobes + 1;
            end
        end
        echo <= config_rdy_o & ~suppress;
    end

    assign config_done_i  = echo;
    assign config_rdata_i = (seed_strobes == corrupt_at && config_o == corrupt_sel) ? '0 :
                            (config_o ? lfsr_stop : lfsr_seed);

    // ---------------- Scoreboard / monitor ----------------
    typedef struct packed {
        logic         sel;
        logic [W-1:0] data;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t mon_e;
    int      strobe_cyc[$];
    int      cyc        = 0;
    int      done_count = 0;
    logic    prev_rdy   = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Compare every strobe against the queued expectation, away from the edge.
    always @(negedge clk_i) begin
        if (config_rdy_o) begin
            strobe_cyc.push_back(cyc);
            check("rdy_back_to_back", 32'(prev_rdy), 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL strobe_unexpected: got sel=%0d data=0x%02h, none expected",
                         config_o, config_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe", 32'({config_o, config_data_o}), 32'({mon_e.sel, mon_e.data}));
            end
        end
        if (done_o) done_count++;
        prev_rdy = config_rdy_o;
    end

    // ---------------- Helpers ----------------
    task automatic push_attempt(input logic [W-1:0] s, input logic [W-1:0] p, input bit full);
        exp_q.push_back(strobe_t'{1'b0, s});
        if (full) exp_q.push_back(strobe_t'{1'b1, p});
    endtask

    task automatic do_start(input logic [W-1:0] s, input logic [W-1:0] p);
        @(negedge clk_i);
        seed_i  = s;
        stop_i  = p;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cycles, output bit got_done);
        cycles   = 0;
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            cycles++;
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            if (error_o && !busy_o) break;
        end
    endtask

    task automatic find_wr_stop(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (config_rdy_o && config_o) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_config"},  32'(config_o),      32'd0);
        check({tag, "_rdy"},     32'(config_rdy_o),  32'd0);
        check({tag, "_data"},    32'(config_data_o), 32'd0);
        check({tag, "_busy"},    32'(busy_o),        32'd0);
        check({tag, "_done"},    32'(done_o),        32'd0);
        check({tag, "_error"},   32'(error_o),       32'd0);
        check({tag, "_retries"}, 32'(retries_o),     32'd0);
    endtask

    // ---------------- Vector table ----------------
    // bad: 0 = clean, 1 = first VFY_SEED reads 0x00, 2 = first VFY_STOP reads 0x00
    typedef struct {
        logic [W-1:0] seed;
        logic [W-1:0] stop;
        int           bad;
        int           exp_retries;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  cycles;
        bit  got_done;
        bit  found;
        int  d0;
        int  s0;

        vecs[0] = '{8'hA5, 8'h3C, 0, 0, 7};
        vecs[1] = '{8'h01, 8'h80, 0, 0, 7};
        vecs[2] = '{8'hA5, 8'h3C, 2, 1, 13};
        vecs[3] = '{8'h5A, 8'hC3, 1, 1, 12};
        vecs[4] = '{8'h7E, 8'hFF, 0, 0, 7};

        nreset_i = 1'b0;
        start_i  = 1'b0;
        seed_i   = '0;
        stop_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        nreset_i = 1'b1;

        // Nominal runs and single readback mismatches.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk_i);
            corrupt_at  = (vecs[v].bad != 0) ? seed_strobes + 1 : -1;
            corrupt_sel = (vecs[v].bad == 2);
            push_attempt(vecs[v].seed, vecs[v].stop, 1'b1);
            if (vecs[v].bad != 0) push_attempt(vecs[v].seed, vecs[v].stop, 1'b1);
            d0 = done_count;
            do_start(vecs[v].seed, vecs[v].stop);
            wait_end(40, cycles, got_done);
            check($sformatf("v%0d_done_seen", v), 32'(got_done), 32'd1);
            check($sformatf("v%0d_latency", v), 32'(cycles), 32'(vecs[v].exp_cycles));
            check($sformatf("v%0d_retries", v), 32'(retries_o), 32'(vecs[v].exp_retries));
            check($sformatf("v%0d_error", v), 32'(error_o), 32'd0);
            repeat (2) @(negedge clk_i);
            check($sformatf("v%0d_lfsr_seed", v), 32'(lfsr_seed), 32'(vecs[v].seed));
            check($sformatf("v%0d_lfsr_stop", v), 32'(lfsr_stop), 32'(vecs[v].stop));
            check($sformatf("v%0d_queue_empty", v), 32'(exp_q.size()), 32'd0);
            check($sformatf("v%0d_done_once", v), 32'(done_count - d0), 32'd1);
            check($sformatf("v%0d_idle", v), 32'(busy_o), 32'd0);
            corrupt_at = -1;
        end

        // Start while busy must be ignored.
        push_attempt(8'hA5, 8'h3C, 1'b1);
        d0 = done_count;
        do_start(8'hA5, 8'h3C);
        find_wr_stop(found);
        check("busy_found_wr_stop", 32'(found), 32'd1);
        @(negedge clk_i);
        seed_i  = 8'h11;
        stop_i  = 8'h22;
        start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("busy_done_once", 32'(done_count - d0), 32'd1);
        check("busy_lfsr_seed", 32'(lfsr_seed), 32'hA5);
        check("busy_lfsr_stop", 32'(lfsr_stop), 32'h3C);
        check("busy_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted in WR_STOP.
        push_attempt(8'h33, 8'h44, 1'b1);
        do_start(8'h33, 8'h44);
        find_wr_stop(found);
        check("rst_found_wr_stop", 32'(found), 32'd1);
        nreset_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_outputs("midrst");
        s0 = strobe_cyc.size();
        @(negedge clk_i);
        nreset_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("midrst_no_strobe", 32'(strobe_cyc.size() - s0), 32'd0);
        check("midrst_idle", 32'(busy_o), 32'd0);

        // Permanent timeout on the seed write.
        suppress = 1'b1;
        strobe_cyc.delete();
        push_attempt(8'hA5, 8'h3C, 1'b0);
        push_attempt(8'hA5, 8'h3C, 1'b0);
        push_attempt(8'hA5, 8'h3C, 1'b0);
        d0 = done_count;
        do_start(8'hA5, 8'h3C);
        wait_end(60, cycles, got_done);
        check("tmo_no_done", 32'(got_done), 32'd0);
        check("tmo_error", 32'(error_o), 32'd1);
        check("tmo_retries", 32'(retries_o), 32'd2);
        check("tmo_busy", 32'(busy_o), 32'd0);
        check("tmo_strobes", 32'(strobe_cyc.size()), 32'd3);
        if (strobe_cyc.size() >= 3) begin
            check("tmo_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(TMO + 1));
            check("tmo_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'(TMO + 1));
        end
        repeat (5) @(negedge clk_i);
        check("tmo_error_sticky", 32'(error_o), 32'd1);
        check("tmo_done_count", 32'(done_count - d0), 32'd0);
        check("tmo_queue_empty", 32'(exp_q.size()), 32'd0);

        // Recovery from ERROR.
        suppress = 1'b0;
        push_attempt(8'hFF, 8'h01, 1'b1);
        do_start(8'hFF, 8'h01);
        check("rec_error_cleared", 32'(error_o), 32'd0);
        check("rec_retries_cleared", 32'(retries_o), 32'd0);
        wait_end(40, cycles, got_done);
        check("rec_done_seen", 32'(got_done), 32'd1);
        check("rec_latency", 32'(cycles), 32'd7);
        repeat (2) @(negedge clk_i);
        check("rec_lfsr_seed", 32'(lfsr_seed), 32'hFF);
        check("rec_lfsr_stop", 32'(lfsr_stop), 32'h01);
        check("rec_error", 32'(error_o), 32'd0);
        check("rec_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_config_master.md
Name: lfsr_config_master

Overview:
Initiator side of the LFSR configuration handshake (config select / ready strobe / data / done echo / readback). On a start request it captures a seed and a stop value. It writes the seed, then the stop value, into the LFSR configuration registers, waiting for the done echo after each write. It then reads both registers back and checks them, retrying the whole sequence on a timeout or a mismatch. It sits between the top-level control/input-pin logic and the LFSR noise generator in the grayscale/Sobel datapath.

Parameters:
MAX_PIXEL_BITS, 8, width of seed, stop and config data (same value as the shared parameter header)
TIMEOUT_CYCLES, 8, maximum cycles spent in a WAIT state before an attempt fails (>=2)
MAX_RETRIES, 2, additional attempts after the first failure before giving up

Ports:
clk_i  in  1  system clock
nreset_i  in  1  synchronous active-low reset
start_i  in  1  request to configure; sampled only in IDLE or ERROR
seed_i  in  MAX_PIXEL_BITS  seed value, captured when start is accepted
stop_i  in  MAX_PIXEL_BITS  stop value, captured when start is accepted
config_o  out  1  register select to LFSR: 0 = seed, 1 = stop
config_rdy_o  out  1  one-cycle write strobe to LFSR
config_data_o  out  MAX_PIXEL_BITS  write data to LFSR
config_done_i  in  1  done echo from LFSR (registered copy of the strobe)
config_rdata_i  in  MAX_PIXEL_BITS  combinational readback of the register selected by config_o
busy_o  out  1  high in every state except IDLE and ERROR
done_o  out  1  one-cycle pulse on successful completion
error_o  out  1  sticky failure flag
retries_o  out  $clog2(MAX_RETRIES+1)  retries used in the current or last run

Behaviour:
- Single clock domain. All state is reset synchronously when nreset_i=0 at a clk_i edge.
- Reset values: state=IDLE, config_o=0, config_rdy_o=0, config_data_o=0, busy_o=0, done_o=0, error_o=0, retries_o=0, captured seed and stop = 0, timeout counter = 0.
- FSM states: IDLE, WR_SEED, WAIT_SEED, WR_STOP, WAIT_STOP, VFY_SEED, VFY_STOP, DONE, ERROR.
- IDLE/ERROR with start_i=1:
  - capture seed_i and stop_i; clear error_o and retries_o; go to WR_SEED.
  - start_i is ignored in every other state, and the captured values do not change.
- WR_SEED: config_o=0, config_rdy_o=1, config_data_o=seed; go to WAIT_SEED next cycle.
- WAIT_SEED:
  - config_o=0, config_rdy_o=0; config_data_o holds seed.
  - config_done_i=1 -> WR_STOP.
  - Otherwise the counter increments. Counter reaching TIMEOUT_CYCLES-1 with no done -> FAIL.
- WR_STOP / WAIT_STOP: identical to WR_SEED / WAIT_SEED but with config_o=1 and data = stop. Success goes to VFY_SEED.
- VFY_SEED: config_o=0. config_rdata_i==seed -> VFY_STOP; otherwise FAIL.
- VFY_STOP: config_o=1. config_rdata_i==stop -> DONE; otherwise FAIL.
- DONE: done_o=1 for exactly one cycle; go to IDLE.
- FAIL handling (not a state; a transition decision):
  - retries_o < MAX_RETRIES -> retries_o+1, restart at WR_SEED with the same captured values.
  - Otherwise -> ERROR, error_o=1 (held until the next accepted start).
- The timeout counter clears on entry to every WAIT state.
- A done echo arriving outside a WAIT state is ignored.
- config_rdy_o is never high for two consecutive cycles.
- Nominal latency against a 1-cycle-echo LFSR: start accepted at edge N, done_o high in cycle N+7.
- Reset asserted mid-sequence aborts it at that edge; no strobe is issued afterwards.

Test Plan:
1. Nominal write and readback:
   - Stimulus: reset, then start with seed=0xA5, stop=0x3C, paired with the LFSR model.
   - Required response: strobes with (config,data) = (0,0xA5) then (1,0x3C); done_o pulses 7 cycles after start; error_o=0; retries_o=0.
2. Timeout on the seed write:
   - Stimulus: suppress config_done_i permanently, with MAX_RETRIES=2.
   - Required response: three WR_SEED strobes spaced TIMEOUT_CYCLES+1 apart; then error_o=1, retries_o=2, busy_o=0, no done_o.
3. Readback mismatch once:
   - Stimulus: corrupt config_rdata_i to 0x00 during the first VFY_STOP only.
   - Required response: the full sequence repeats; done_o pulses; retries_o=1.
4. Start while busy:
   - Stimulus: pulse start_i with seed=0x11 during WAIT_STOP.
   - Required response: ignored; the LFSR still ends with seed 0xA5 and stop 0x3C; exactly one done_o pulse.
5. Reset mid-sequence:
   - Stimulus: assert nreset_i in WR_STOP.
   - Required response: at the next edge all outputs are at their reset values, and no config_rdy_o appears until a new start.
6. Recovery from ERROR:
   - Stimulus: after scenario 2, restore the done echo and start with seed=0xFF, stop=0x01.
   - Required response: error_o clears on start, done_o pulses, readback matches.
